// File: rtl/code_lock_ps2.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_ps2
// Brief    : PS/2 set-2 keyboard code lock with digit entry, edit keys,
//            consecutive-failure counting and a timed lockout.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_ps2 #(
   parameter int                  DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] CODE        = 16'h1234,
   parameter int                  MAX_FAIL    = 3,
   parameter int                  LOCK_CYCLES = 50_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            ps2_data,
   input  logic                  ps2_new_data,
   output logic                  on_out,
   output logic                  off_out,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  lockout,
   output logic [3:0]            fail_count
);

   localparam int                c_BUF_W     = 4 * DIGITS;
   localparam int                c_CNT_W     = $clog2(LOCK_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LOCK_CYCLES - 1);
   localparam logic [3:0]        c_MAX_FAIL  = 4'(MAX_FAIL);
   localparam logic [DIGITS-1:0] c_FULL      = '1;

   localparam logic [7:0]        c_KEY_BREAK = 8'hF0;
   localparam logic [7:0]        c_KEY_ENTER = 8'h5A;
   localparam logic [7:0]        c_KEY_BKSP  = 8'h66;
   localparam logic [7:0]        c_KEY_ESC   = 8'h76;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BREAK   = 2'd1,
      S_LOCKOUT = 2'd2
   } state_t;

   state_t               state_q,  state_d;
   logic [c_BUF_W-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]    valid_q,  valid_d;
   logic                 on_q,     on_d;
   logic [3:0]           fail_q,   fail_d;
   logic                 lock_q,   lock_d;
   logic [c_CNT_W-1:0]   lcnt_q,   lcnt_d;

   logic                 w_is_digit;
   logic [3:0]           w_digit_val;
   logic [3:0]           w_fail_inc;

   always_comb begin
      w_is_digit  = 1'b1;
      w_digit_val = 4'd0;
      case (ps2_data)
         8'h45:   w_digit_val = 4'd0;
         8'h16:   w_digit_val = 4'd1;
         8'h1E:   w_digit_val = 4'd2;
         8'h26:   w_digit_val = 4'd3;
         8'h25:   w_digit_val = 4'd4;
         8'h2E:   w_digit_val = 4'd5;
         8'h36:   w_digit_val = 4'd6;
         8'h3D:   w_digit_val = 4'd7;
         8'h3E:   w_digit_val = 4'd8;
         8'h46:   w_digit_val = 4'd9;
         default: w_is_digit  = 1'b0;
      endcase
   end

   assign w_fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

   // The valid mask is a thermometer code, so shifting it alongside the
   // buffer gives the saturating entry count for free.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      valid_d  = valid_q;
      on_d     = on_q;
      fail_d   = fail_q;
      lcnt_d   = lcnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (ps2_new_data) begin
               if (ps2_data == c_KEY_BREAK) begin
                  state_d = S_BREAK;
               end else if (w_is_digit) begin
                  digits_d = (digits_q << 4) | c_BUF_W'(w_digit_val);
                  valid_d  = (valid_q << 1) | DIGITS'(1'b1);
               end else if (ps2_data == c_KEY_BKSP) begin
                  digits_d = digits_q >> 4;
                  valid_d  = valid_q >> 1;
               end else if (ps2_data == c_KEY_ESC) begin
                  digits_d = '0;
                  valid_d  = '0;
               end else if (ps2_data == c_KEY_ENTER) begin
                  digits_d = '0;
                  valid_d  = '0;
                  if (valid_q == c_FULL && digits_q == CODE) begin
                     on_d   = ~on_q;
                     fail_d = 4'd0;
                  end else begin
                     fail_d = w_fail_inc;
                     if (w_fail_inc == c_MAX_FAIL) begin
                        state_d = S_LOCKOUT;
                        lcnt_d  = c_CNT_LOAD;
                     end
                  end
               end
            end
         end

         S_BREAK: begin
            if (ps2_new_data) begin
               state_d = S_IDLE;
            end
         end

         S_LOCKOUT: begin
            if (lcnt_q == '0) begin
               state_d  = S_IDLE;
               fail_d   = 4'd0;
               digits_d = '0;
               valid_d  = '0;
            end else begin
               lcnt_d = lcnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign lock_d = (state_d == S_LOCKOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         digits_q <= '0;
         valid_q  <= '0;
         on_q     <= 1'b0;
         fail_q   <= 4'd0;
         lock_q   <= 1'b0;
         lcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         on_q     <= on_d;
         fail_q   <= fail_d;
         lock_q   <= lock_d;
         lcnt_q   <= lcnt_d;
      end
   end

   assign on_out      = on_q;
   assign off_out     = ~on_q;
   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign lockout     = lock_q;
   assign fail_count  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ps2.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_ps2
// Brief    : Directed and randomized checking of code_lock_ps2 against a
//            digit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_ps2;

   localparam int c_LOCK = 20;

   logic        clk;
   logic        reset;
   logic [7:0]  ps2_data;
   logic        ps2_new_data;
   logic        on_out;
   logic        off_out;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        lockout;
   logic [3:0]  fail_count;

   int n_checks;
   int n_errors;

   // Reference model state: entered digits oldest-first
   int m_q[$];
   bit m_on;
   int m_fail;
   int m_lock;
   bit m_brk;

   code_lock_ps2 #(
      .DIGITS      (4),
      .CODE        (16'h1234),
      .MAX_FAIL    (3),
      .LOCK_CYCLES (c_LOCK)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_data     (ps2_data),
      .ps2_new_data (ps2_new_data),
      .on_out       (on_out),
      .off_out      (off_out),
      .digits       (digits),
      .digit_valid  (digit_valid),
      .lockout      (lockout),
      .fail_count   (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] key_of(input int d);
      case (d)
         0: return 8'h45;  1: return 8'h16;  2: return 8'h1E;  3: return 8'h26;
         4: return 8'h25;  5: return 8'h2E;  6: return 8'h36;  7: return 8'h3D;
         8: return 8'h3E;  default: return 8'h46;
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_on   = 1'b0;
      m_fail = 0;
      m_lock = 0;
      m_brk  = 1'b0;
   endtask

   task automatic model_edge(input bit stb, input logic [7:0] b);
      int  d;
      bit  match;
      int  code[4];
      code = '{1, 2, 3, 4};
      d = -1;
      for (int k = 0; k < 10; k++) if (key_of(k) == b) d = k;
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) begin
            m_fail = 0;
            m_q.delete();
         end
      end else if (stb) begin
         if (m_brk) m_brk = 1'b0;
         else if (b == 8'hF0) m_brk = 1'b1;
         else if (d >= 0) begin
            m_q.push_back(d);
            if (m_q.size() > 4) void'(m_q.pop_front());
         end else if (b == 8'h66) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
         end else if (b == 8'h76) begin
            m_q.delete();
         end else if (b == 8'h5A) begin
            match = (m_q.size() == 4);
            if (match) for (int k = 0; k < 4; k++) if (m_q[k] != code[k]) match = 1'b0;
            if (match) begin
               m_on   = !m_on;
               m_fail = 0;
            end else begin
               m_fail = (m_fail >= 15) ? 15 : m_fail + 1;
               if (m_fail == 3) m_lock = c_LOCK;
            end
            m_q.delete();
         end
      end
   endtask

   task automatic compare_all();
      logic [15:0] ed;
      logic [3:0]  ev;
      ed = 16'h0;
      for (int i = 0; i < m_q.size(); i++)
         ed = ed | (16'(m_q[m_q.size() - 1 - i]) << (4 * i));
      ev = 4'((1 << m_q.size()) - 1);
      check("on_out",      32'(on_out),      32'(m_on));
      check("off_out",     32'(off_out),     32'(!m_on));
      check("digits",      32'(digits),      32'(ed));
      check("digit_valid", 32'(digit_valid), 32'(ev));
      check("lockout",     32'(lockout),     32'(m_lock > 0));
      check("fail_count",  32'(fail_count),  32'(m_fail));
   endtask

   task automatic send(input bit stb, input logic [7:0] b);
      ps2_new_data = stb;
      ps2_data     = b;
      @(posedge clk);
      model_edge(stb, b);
      #1;
      ps2_new_data = 1'b0;
      @(negedge clk);
      compare_all();
   endtask

   // Sends n bytes from the packed vector, first byte in the highest used slot
   task automatic seq(input logic [63:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         send(1'b1, bytes[8*(n-1-i) +: 8]);
         send(1'b0, 8'h00);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 8'h00);
   endtask

   initial begin
      int          r;
      logic [7:0]  b;
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b1;
      ps2_new_data = 1'b0;
      ps2_data     = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      compare_all();

      // Correct code toggles on, a repeat toggles off
      seq(64'h16_1E_26_25_5A, 5);
      check("plan_on_after_code", 32'(on_out), 32'd1);
      seq(64'h16_1E_26_25_5A, 5);
      check("plan_off_after_repeat", 32'(on_out), 32'd0);

      // Break codes consume the following byte
      seq(64'h16_F0_16_1E_F0_1E, 6);
      check("plan_break_digits", 32'(digits), 32'h0012);
      check("plan_break_valid", 32'(digit_valid), 32'h3);
      seq(64'h76, 1);

      // Backspace removes the duplicate digit
      seq(64'h16_1E_26_26_66_25_5A, 7);
      check("plan_bksp_on", 32'(on_out), 32'd1);
      seq(64'h16_1E_26_25_2E, 5);
      check("plan_overflow_digits", 32'(digits), 32'h2345);
      seq(64'h5A, 1);
      check("plan_overflow_fail", 32'(fail_count), 32'd1);

      // Two more failures enter lockout; keys during lockout are ignored
      seq(64'h16_5A, 2);
      send(1'b1, 8'h5A);
      check("plan_lock_rise", 32'(lockout), 32'd1);
      check("plan_lock_fail", 32'(fail_count), 32'd3);
      for (int i = 0; i < 8; i++) send(1'b1, key_of(i));
      send(1'b1, 8'hF0);
      idle(12);
      check("plan_lock_clear_fail", 32'(fail_count), 32'd0);
      seq(64'h16_1E_26_25_5A, 5);
      check("plan_after_lock_on", 32'(on_out), 32'd0);

      // Extended Enter prefix
      seq(64'h16_1E_26_25_E0_5A, 6);
      check("plan_e0_enter", 32'(on_out), 32'd1);

      // Reset during lockout: immediate clear, dominates a strobe
      seq(64'h16_5A_16_5A_16_5A, 6);
      idle(3);
      ps2_new_data = 1'b1;
      ps2_data     = 8'h16;
      reset        = 1'b1;
      model_reset();
      #1;
      check("async_reset_lockout", 32'(lockout), 32'd0);
      check("async_reset_on", 32'(on_out), 32'd0);
      @(posedge clk);
      #1;
      ps2_new_data = 1'b0;
      @(negedge clk);
      compare_all();
      reset = 1'b0;
      seq(64'h16_1E, 2);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("reset_entry_digits", 32'(digits), 32'd0);
      check("reset_entry_off", 32'(off_out), 32'd1);
      reset = 1'b0;
      idle(1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            seq(64'h16_1E_26_25_5A, 5);
         end else if (r < 30) begin
            send(1'b0, 8'($urandom));
         end else begin
            r = int'($urandom_range(0, 99));
            if      (r < 30) b = key_of(int'($urandom_range(0, 9)));
            else if (r < 50) b = key_of(int'($urandom_range(1, 4)));
            else if (r < 58) b = 8'h5A;
            else if (r < 66) b = 8'h66;
            else if (r < 71) b = 8'h76;
            else if (r < 80) b = 8'hF0;
            else if (r < 86) b = 8'hE0;
            else             b = 8'($urandom);
            send(1'b1, b);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
